// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding and read-latency bounds.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        RWAIT = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_PROC = 1'b0,
        OWN_EXT  = 1'b1
    } owner_t;

    localparam int RD_LAT_MAX = 7;
    localparam int CNT_W      = 3;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle of dmem_arbiter: processor port, external-host port, memory side and busy flag.
// Handshake: req is held with we/addr/wdata until a one-cycle gnt; a read answers later with a one-cycle rvalid.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              proc_req;
    logic              proc_we;
    logic [ADDR_W-1:0] proc_addr;
    logic [DATA_W-1:0] proc_wdata;
    logic              proc_gnt;
    logic              proc_rvalid;
    logic [DATA_W-1:0] proc_rdata;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_rden;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    logic              busy;

    modport slave (
        input  proc_req, proc_we, proc_addr, proc_wdata,
        output proc_gnt, proc_rvalid, proc_rdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_addr, mem_data, mem_rden, mem_wren,
        input  mem_q,
        output busy
    );

    modport master (
        output proc_req, proc_we, proc_addr, proc_wdata,
        input  proc_gnt, proc_rvalid, proc_rdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_addr, mem_data, mem_rden, mem_wren,
        output mem_q,
        input  busy
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Owner select for dmem_arbiter. DMEM_ARB_RR_EN: round-robin against the last owner;
// otherwise fixed priority with the external host ahead of the processor.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic   proc_req,
    input  logic   ext_req,
`ifdef DMEM_ARB_RR_EN
    input  owner_t last_owner,
`endif
    output logic   any_req,
    output owner_t owner
);

    always_comb begin
        any_req = proc_req | ext_req;
`ifdef DMEM_ARB_RR_EN
        if (proc_req && ext_req) begin
            owner = (last_owner == OWN_PROC) ? OWN_EXT : OWN_PROC;
        end else begin
            owner = ext_req ? OWN_EXT : OWN_PROC;
        end
`else
        owner = ext_req ? OWN_EXT : OWN_PROC;
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (processor / external host) with one outstanding access.
// Build macro DMEM_ARB_RR_EN selects round-robin arbitration instead of ext-first priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus,
    output state_t        dbg_state
);

    // Out-of-range latencies are clamped so the 3-bit counter can never wrap.
    localparam int LAT_LOAD = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    owner_t            owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] proc_rdata_q;
    logic [DATA_W-1:0] ext_rdata_q;
    logic              proc_gnt_q;
    logic              ext_gnt_q;
    logic              proc_rvalid_q;
    logic              ext_rvalid_q;
    logic              rden_q;
    logic              wren_q;
    logic              busy_q;

    logic              any_req;
    owner_t            pick_owner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
`ifdef DMEM_ARB_RR_EN
    owner_t            last_owner;
`endif

    dmem_arb_pick u_pick (
        .proc_req   (bus.proc_req),
        .ext_req    (bus.ext_req),
`ifdef DMEM_ARB_RR_EN
        .last_owner (last_owner),
`endif
        .any_req    (any_req),
        .owner      (pick_owner)
    );

    assign sel_we    = (pick_owner == OWN_EXT) ? bus.ext_we    : bus.proc_we;
    assign sel_addr  = (pick_owner == OWN_EXT) ? bus.ext_addr  : bus.proc_addr;
    assign sel_wdata = (pick_owner == OWN_EXT) ? bus.ext_wdata : bus.proc_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            owner_q       <= OWN_PROC;
            we_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            proc_rdata_q  <= '0;
            ext_rdata_q   <= '0;
            proc_gnt_q    <= 1'b0;
            ext_gnt_q     <= 1'b0;
            proc_rvalid_q <= 1'b0;
            ext_rvalid_q  <= 1'b0;
            rden_q        <= 1'b0;
            wren_q        <= 1'b0;
            busy_q        <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_owner    <= OWN_PROC;
`endif
        end else begin
            // Grant, enables and rvalid are single-cycle pulses.
            proc_gnt_q    <= 1'b0;
            ext_gnt_q     <= 1'b0;
            proc_rvalid_q <= 1'b0;
            ext_rvalid_q  <= 1'b0;
            rden_q        <= 1'b0;
            wren_q        <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_q    <= pick_owner;
                        we_q       <= sel_we;
                        addr_q     <= sel_addr;
                        data_q     <= sel_wdata;
                        proc_gnt_q <= (pick_owner == OWN_PROC);
                        ext_gnt_q  <= (pick_owner == OWN_EXT);
                        wren_q     <= sel_we;
                        rden_q     <= !sel_we;
                        busy_q     <= 1'b1;
                        state      <= CMD;
`ifdef DMEM_ARB_RR_EN
                        last_owner <= pick_owner;
`endif
                    end
                end
                CMD: begin
                    if (we_q) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt   <= CNT_W'(LAT_LOAD);
                        state <= RWAIT;
                    end
                end
                RWAIT: begin
                    cnt <= cnt - 1'b1;
                    // Last wait cycle: mem_q is valid now, RD_LAT cycles after the rden pulse.
                    if (cnt == CNT_W'(1)) begin
                        if (owner_q == OWN_EXT) begin
                            ext_rdata_q  <= bus.mem_q;
                            ext_rvalid_q <= 1'b1;
                        end else begin
                            proc_rdata_q  <= bus.mem_q;
                            proc_rvalid_q <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.proc_gnt    = proc_gnt_q;
    assign bus.proc_rvalid = proc_rvalid_q;
    assign bus.proc_rdata  = proc_rdata_q;
    assign bus.ext_gnt     = ext_gnt_q;
    assign bus.ext_rvalid  = ext_rvalid_q;
    assign bus.ext_rdata   = ext_rdata_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_data    = data_q;
    assign bus.mem_rden    = rden_q;
    assign bus.mem_wren    = wren_q;
    assign bus.busy        = busy_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (RD_LAT 2, 1, 7) against a transaction-level reference model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n;

    // Index [k][p]: k = instance, p = 0 processor, 1 external host.
    logic          req   [NI][2];
    logic          we    [NI][2];
    logic [AW-1:0] addr  [NI][2];
    logic [DW-1:0] wdata [NI][2];
    logic          gnt   [NI][2];
    logic          rv    [NI][2];
    logic [DW-1:0] rdata [NI][2];
    logic [AW-1:0] maddr [NI];
    logic [DW-1:0] mdata [NI];
    logic          rden  [NI];
    logic          wren  [NI];
    logic          busy  [NI];
    state_t        dbg   [NI];

    function automatic int lat_of(int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 7);
    endfunction

    function automatic logic [DW-1:0] init_val(int a);
        if (a == 5) return 16'hBEEF;
        return DW'(a * 40503 + 7);
    endfunction

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 2 : ((gi == 1) ? 1 : 7);
        dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        logic [DW-1:0] env_mem [512];
        logic [DW-1:0] pipe [8];

        assign bus.proc_req   = req[gi][0];
        assign bus.proc_we    = we[gi][0];
        assign bus.proc_addr  = addr[gi][0];
        assign bus.proc_wdata = wdata[gi][0];
        assign bus.ext_req    = req[gi][1];
        assign bus.ext_we     = we[gi][1];
        assign bus.ext_addr   = addr[gi][1];
        assign bus.ext_wdata  = wdata[gi][1];
        assign gnt[gi][0]     = bus.proc_gnt;
        assign rv[gi][0]      = bus.proc_rvalid;
        assign rdata[gi][0]   = bus.proc_rdata;
        assign gnt[gi][1]     = bus.ext_gnt;
        assign rv[gi][1]      = bus.ext_rvalid;
        assign rdata[gi][1]   = bus.ext_rdata;
        assign maddr[gi]      = bus.mem_addr;
        assign mdata[gi]      = bus.mem_data;
        assign rden[gi]       = bus.mem_rden;
        assign wren[gi]       = bus.mem_wren;
        assign busy[gi]       = bus.busy;
        assign bus.mem_q      = pipe[L-1];

        dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .bus       (bus),
            .dbg_state (dbg[gi])
        );

        initial for (int a = 0; a < 512; a++) env_mem[a] <= init_val(a);

        // Memory with RD_LAT-cycle read pipe; junk flows through when no read is issued.
        always @(posedge clk) begin
            pipe[0] <= bus.mem_rden ? env_mem[bus.mem_addr] : DW'($urandom);
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
            if (bus.mem_wren) env_mem[bus.mem_addr] <= bus.mem_data;
        end
    end

    int            t;
    int            n_chk;
    int            n_err;
    bit            act      [NI];
    int            g_at     [NI];
    int            free_at  [NI];
    int            own      [NI];
    bit            twe      [NI];
    logic [AW-1:0] taddr    [NI];
    logic [AW-1:0] cur_addr [NI];
    logic [DW-1:0] cur_data [NI];
    logic [DW-1:0] exp_rd   [NI][2];
    logic [DW-1:0] ref_mem  [NI][512];
    int            last_gnt_cyc [NI][2];
    int            last_rv_cyc  [NI][2];
`ifdef DMEM_ARB_RR_EN
    int            last_own [NI];
`endif

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s inst=%0d cycle=%0d observed=%0h expected=%0h", tag, k, t, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        act[k]      = 1'b0;
        free_at[k]  = t + 1;
        cur_addr[k] = '0;
        cur_data[k] = '0;
        exp_rd[k][0] = '0;
        exp_rd[k][1] = '0;
`ifdef DMEM_ARB_RR_EN
        last_own[k] = 0;
`endif
    endtask

    // Decide, from this cycle's inputs, whether a transaction starts and when its phases fall.
    task automatic schedule(input int k);
        int p;
        if (!rst_n) begin
            model_reset(k);
            return;
        end
        if (t >= free_at[k] && (req[k][0] || req[k][1])) begin
            p = req[k][1] ? 1 : 0;
`ifdef DMEM_ARB_RR_EN
            if (req[k][0] && req[k][1]) p = (last_own[k] == 0) ? 1 : 0;
            last_own[k] = p;
`endif
            act[k]      = 1'b1;
            g_at[k]     = t + 1;
            own[k]      = p;
            twe[k]      = we[k][p];
            taddr[k]    = addr[k][p];
            cur_addr[k] = addr[k][p];
            cur_data[k] = wdata[k][p];
            if (twe[k]) begin
                ref_mem[k][addr[k][p]] = wdata[k][p];
                free_at[k] = t + 2;
            end else begin
                free_at[k] = t + lat_of(k) + 3;
            end
        end
    endtask

    task automatic check(input int k);
        int L        = lat_of(k);
        bit in_cmd   = act[k] && (t == g_at[k]);
        bit in_resp  = act[k] && !twe[k] && (t == g_at[k] + L + 1);
        int span     = twe[k] ? 1 : L + 2;
        bit bz       = act[k] && (t >= g_at[k]) && (t < g_at[k] + span);
        if (in_resp) exp_rd[k][own[k]] = ref_mem[k][taddr[k]];
        for (int p = 0; p < 2; p++) begin
            if (gnt[k][p]) last_gnt_cyc[k][p] = t;
            if (rv[k][p])  last_rv_cyc[k][p]  = t;
        end
        chk("proc_gnt",    k, gnt[k][0],   in_cmd && own[k] == 0);
        chk("ext_gnt",     k, gnt[k][1],   in_cmd && own[k] == 1);
        chk("proc_rvalid", k, rv[k][0],    in_resp && own[k] == 0);
        chk("ext_rvalid",  k, rv[k][1],    in_resp && own[k] == 1);
        chk("proc_rdata",  k, rdata[k][0], exp_rd[k][0]);
        chk("ext_rdata",   k, rdata[k][1], exp_rd[k][1]);
        chk("mem_wren",    k, wren[k],     in_cmd && twe[k]);
        chk("mem_rden",    k, rden[k],     in_cmd && !twe[k]);
        chk("mem_addr",    k, maddr[k],    cur_addr[k]);
        chk("mem_data",    k, mdata[k],    cur_data[k]);
        chk("busy",        k, busy[k],     bz);
        chk("state_idle",  k, dbg[k] == IDLE, !bz);
    endtask

    task automatic tick();
        for (int k = 0; k < NI; k++) schedule(k);
        @(posedge clk);
        #1;
        t++;
        for (int k = 0; k < NI; k++) check(k);
    endtask

    task automatic put(input int k, input int p, input bit w, input int a, input int d);
        req[k][p]   = 1'b1;
        we[k][p]    = w;
        addr[k][p]  = AW'(a);
        wdata[k][p] = DW'(d);
    endtask

    task automatic put_all(input int p, input bit w, input int a, input int d);
        for (int k = 0; k < NI; k++) put(k, p, w, a, d);
    endtask

    task automatic drop_all(input int p);
        for (int k = 0; k < NI; k++) req[k][p] = 1'b0;
    endtask

    function automatic int rand_addr();
        return ($urandom_range(15, 0) == 0) ? 'h1FF : int'($urandom_range(15, 0));
    endfunction

    task automatic rand_drive(input int k, input int p);
        if (gnt[k][p]) begin
            if ($urandom_range(1, 0) == 1) put(k, p, 1'($urandom_range(1, 0)), rand_addr(), int'($urandom));
            else req[k][p] = 1'b0;
        end else if (req[k][p]) begin
            if ($urandom_range(9, 0) == 0) req[k][p] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
            put(k, p, 1'($urandom_range(1, 0)), rand_addr(), int'($urandom));
        end
    endtask

    initial begin
        int t0;
        int gq[$];
        bit done [NI];
        int exp_own;
        n_chk = 0;
        n_err = 0;
        t     = 0;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < 2; p++) begin
                req[k][p] = 1'b0; we[k][p] = 1'b0; addr[k][p] = '0; wdata[k][p] = '0;
                last_gnt_cyc[k][p] = -1; last_rv_cyc[k][p] = -1;
            end
            for (int a = 0; a < 512; a++) ref_mem[k][a] = init_val(a);
            model_reset(k);
        end

        // Reset values
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Processor read of 0x005 on all latencies
        t0 = t;
        put_all(0, 1'b0, 'h005, 0);
        tick();
        drop_all(0);
        repeat (10) tick();
        for (int k = 0; k < NI; k++) begin
            chk("read_gnt_cycle",    k, last_gnt_cyc[k][0] - t0, 1);
            chk("read_rvalid_cycle", k, last_rv_cyc[k][0] - t0, lat_of(k) + 2);
            chk("read_rdata_beef",   k, rdata[k][0], 16'hBEEF);
        end

        // External write 0x010 <= 0x1234
        put_all(1, 1'b1, 'h010, 'h1234);
        tick();
        for (int k = 0; k < NI; k++) begin
            chk("wr_ext_gnt",  k, gnt[k][1], 1);
            chk("wr_mem_wren", k, wren[k], 1);
            chk("wr_mem_addr", k, maddr[k], 'h010);
            chk("wr_mem_data", k, mdata[k], 'h1234);
        end
        drop_all(1);
        tick();
        for (int k = 0; k < NI; k++) chk("wr_busy_low", k, busy[k], 0);
        tick();

        // Both ports streaming writes: grant order
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        put_all(0, 1'b1, 1, 'h1111);
        put_all(1, 1'b1, 2, 'h2222);
        for (int i = 0; i < 30 && gq.size() < 4; i++) begin
            tick();
            if (gnt[0][0]) gq.push_back(0);
            if (gnt[0][1]) gq.push_back(1);
            for (int k = 0; k < NI; k++)
                for (int p = 0; p < 2; p++)
                    if (gnt[k][p]) put(k, p, 1'b1, rand_addr(), int'($urandom));
        end
        chk("both_grant_count", 0, gq.size(), 4);
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp_own = (i % 2 == 0) ? 1 : 0;
`else
            exp_own = 1;
`endif
            chk("both_grant_order", 0, (i < gq.size()) ? gq[i] : -1, exp_own);
        end
        drop_all(0);
        drop_all(1);
        tick();
        tick();

        // Processor request arriving while an external read waits
        put_all(1, 1'b0, 3, 0);
        tick();
        drop_all(1);
        tick();
        put_all(0, 1'b0, 4, 0);
        for (int k = 0; k < NI; k++) done[k] = 1'b0;
        for (int i = 0; i < 30 && !(done[0] && done[1] && done[2]); i++) begin
            tick();
            for (int k = 0; k < NI; k++)
                if (!done[k] && gnt[k][0]) begin
                    done[k] = 1'b1;
                    req[k][0] = 1'b0;
                end
        end
        for (int k = 0; k < NI; k++) begin
            chk("wait_granted", k, done[k], 1);
            chk("wait_gnt_gap", k, last_gnt_cyc[k][0] - last_rv_cyc[k][1], 2);
        end
        drop_all(0);
        repeat (12) tick();

        // Reset during the read wait
        put_all(0, 1'b0, 7, 0);
        tick();
        drop_all(0);
        tick();
        rst_n = 1'b0;
        tick();
        for (int k = 0; k < NI; k++) begin
            chk("abort_busy",   k, busy[k], 0);
            chk("abort_rvalid", k, rv[k][0], 0);
        end
        rst_n = 1'b1;
        repeat (10) tick();
        put_all(1, 1'b0, 9, 0);
        tick();
        for (int k = 0; k < NI; k++) chk("abort_regrant", k, gnt[k][1], 1);
        drop_all(1);
        repeat (10) tick();

        // Random traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            rst_n = ($urandom_range(299, 0) != 0);
            for (int k = 0; k < NI; k++)
                for (int p = 0; p < 2; p++) rand_drive(k, p);
            tick();
        end
        rst_n = 1'b1;
        drop_all(0);
        drop_all(1);
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d observed=running expected=finished", t);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter RD_LAT, default 2, memory read latency in cycles (mem_rden cycle to mem_q valid); legal range 1..7.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 proc_req / proc_we  in  1 / 1  processor access request (held until grant) / write select.
REQ-007 proc_addr / proc_wdata  in  ADDR_W / DATA_W  processor address / write data.
REQ-008 proc_gnt / proc_rvalid  out  1 / 1  processor grant pulse / read data valid pulse.
REQ-009 proc_rdata  out  DATA_W  processor read data.
REQ-010 ext_req, ext_we, ext_addr, ext_wdata, ext_gnt, ext_rvalid, ext_rdata: external-host port, same directions, widths and meanings as the processor port.
REQ-011 mem_addr / mem_data  out  ADDR_W / DATA_W  memory address / write data.
REQ-012 mem_rden / mem_wren  out  1 / 1  memory read / write enable.
REQ-013 mem_q  in  DATA_W  memory read data.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 FSM states IDLE, CMD, RWAIT, RESP; all outputs registered.
REQ-016 IDLE: if any req is high, select an owner, latch its addr/wdata/we, go to CMD next cycle; else stay in IDLE.
REQ-017 CMD (exactly 1 cycle): owner gnt=1; mem_wren=we; mem_rden=!we; write -> IDLE, read -> RWAIT.
REQ-018 RWAIT: lasts exactly RD_LAT cycles, counted by a 3-bit down-counter; at end of its last cycle capture mem_q into owner rdata; -> RESP.
REQ-019 RESP (1 cycle): owner rvalid=1; -> IDLE.
REQ-020 Latency: req seen in IDLE cycle i gives gnt in i+1; write done in i+1; read rvalid in i+RD_LAT+2.
REQ-021 Writes sustain one access per 2 cycles; only one transaction is outstanding.
REQ-022 mem_addr/mem_data stay stable from CMD until return to IDLE.
REQ-023 mem_rden/mem_wren are high only in CMD and never high together.
REQ-024 rdata holds its last captured value until the next read by the same port.
REQ-025 req sampled only in IDLE; requests during CMD/RWAIT/RESP wait; req dropped before gnt is abandoned with no side effect.
REQ-026 Requester deasserts req or presents its next request in the cycle after gnt; a req high in IDLE after gnt counts as a new request.
REQ-027 Simultaneous requests are resolved per REQ-031.

Reset
REQ-028 rst_n low at a clock edge: state=IDLE, counter=0, all gnt/rvalid/mem_rden/mem_wren/busy=0, mem_addr/mem_data/rdata=0, arbitration pointer=processor-last.
REQ-029 Reset mid-transaction aborts it: no gnt, rvalid or memory enable after the reset edge.

Configuration
REQ-030 Macro DMEM_ARB_RR_EN.
REQ-031 Defined: round-robin; on simultaneous requests the port not granted last wins; pointer updates on every grant. Undefined: fixed priority, ext over proc; pointer logic absent.

Structure
REQ-032 Package dmem_arb_pkg holds the FSM state encoding, owner encoding (OWN_PROC, OWN_EXT) and the RD_LAT bound constant.
REQ-033 One sub-module, dmem_arb_pick: combinational owner select from both reqs and the pointer.

Verification
REQ-034 Proc read addr 0x005, RD_LAT=2, mem_q=0xBEEF: proc_gnt at cycle 1, mem_rden at cycle 1, proc_rvalid at cycle 4 with proc_rdata=0xBEEF.
REQ-035 Ext write addr 0x010 data 0x1234: ext_gnt and mem_wren at cycle 1 with mem_addr=0x010, mem_data=0x1234; busy low at cycle 2.
REQ-036 Both req held for 4 writes: with DMEM_ARB_RR_EN grants ext,proc,ext,proc; without it ext,ext,ext,ext while ext_req stays high.
REQ-037 proc_req during ext read RWAIT: proc_gnt only after ext_rvalid, in the cycle after return to IDLE.
REQ-038 rst_n low during RWAIT: no rvalid, busy=0 and outputs at reset values the next cycle; a new request is granted normally after rst_n is released.
REQ-039 RD_LAT=1 and RD_LAT=7 reads: rvalid at cycles 3 and 9.
